row_compressor: RTL and testbench
=================================

ROW_COMPRESSOR -- requirements
Module: row_compressor

Interface
REQ-001 SHALL have parameter SECTION_SIZE, default 4, bit width of one run-length section.
REQ-002 SHALL have parameter ROW_SIZE, default 16, bits per uncompressed row.
REQ-003 SHALL have parameter COMP_SIZE, default 16, bits per compressed word; NSECT = COMP_SIZE/SECTION_SIZE sections.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 start  input  1  request to compress rowData; sampled only in IDLE.
REQ-008 rowData  input  ROW_SIZE  row to compress; MSB is the first bit.
REQ-009 compressedData  output  COMP_SIZE  run-length word; section k occupies bits [k*SECTION_SIZE +: SECTION_SIZE].
REQ-010 busy  output  1  high in SCAN and FINISH.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 overflow  output  1  row not representable; valid with done, held until next accepted start.

Function
REQ-013 Encoding SHALL be alternating runs scanned MSB to LSB, first run = 0s: section 0 = leading-zero count (0 if row MSB is 1), section 1 = following-ones count, and so on; unused sections = 0.
REQ-014 Final run SHALL be omitted when it is a run of 0s; an all-zero row encodes to 0.
REQ-015 FSM states SHALL be IDLE, SCAN, FINISH.
REQ-016 IDLE + start=1: latch rowData, clear compressedData and overflow, runLen=0, digit=0, bitIdx=ROW_SIZE-1, sectIdx=0, go to SCAN.
REQ-017 SCAN SHALL consume exactly one row bit per cycle, for exactly ROW_SIZE cycles.
REQ-018 Bit equal to digit: runLen++; otherwise write runLen to section sectIdx, sectIdx++, toggle digit, runLen=1.
REQ-019 After the last bit, a pending run of 1s SHALL be written to section sectIdx; go to FINISH.
REQ-020 Writing a section with sectIdx >= NSECT, or runLen > 2^SECTION_SIZE-1, SHALL set overflow and discard that write; scanning continues; latency unchanged.
REQ-021 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-022 Latency: start accepted at edge 0, done high during the cycle after edge ROW_SIZE+1.
REQ-023 compressedData SHALL hold its value from FINISH until the next accepted start.
REQ-024 start while busy SHALL be ignored (no queuing).
REQ-025 Arithmetic: runLen and sectIdx counters SHALL be wide enough for ROW_SIZE and NSECT+1 without wrap.

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE; compressedData=0, busy=0, done=0, overflow=0; internal counters cleared.
REQ-027 rst=0 mid-SCAN SHALL abort the row with no done pulse; rst has priority over start.

Structure
REQ-028 SECTION_SIZE, ROW_SIZE, COMP_SIZE defaults and the FSM state typedef SHALL live in the shared IO package, also used by the decompressor.
REQ-029 No sub-module is natural; row_compressor SHALL be one flat module.

Verification
REQ-030 rowData=16'hF00F, start -> done after 17 cycles, compressedData=16'h4840, overflow=0.
REQ-031 rowData=16'h0F00 -> compressedData=16'h0044 (trailing zeros omitted); 16'h00FF -> 16'h0088.
REQ-032 rowData=16'h0000 -> compressedData=0, overflow=0; 16'hFFFF -> overflow=1 (run 16 > 15).
REQ-033 rowData=16'hAAAA -> overflow=1 (runs exceed 4 sections), done still at cycle 17.
REQ-034 Reset at cycle 8 of SCAN -> no done, all outputs 0; start during busy ignored; back-to-back rows each correct.
REQ-035 Loopback: compressedData fed to the decompressor reproduces rowData for 1000 random rows with overflow=0.

Source files
------------

// File: rtl/row_compressor_pkg.sv
// Shared IO definitions for the row compressor and its matching decompressor.
package row_compressor_pkg;

   localparam int unsigned DEF_SECTION_SIZE = 4;
   localparam int unsigned DEF_ROW_SIZE     = 16;
   localparam int unsigned DEF_COMP_SIZE    = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_FINISH = 2'd2
   } cmp_state_e;

endpackage

// File: rtl/row_compressor.sv
// Run-length compressor: scans one row MSB-first, one bit per cycle, and packs
// alternating 0/1 run lengths (zeros first) into fixed-width sections.
module row_compressor
   import row_compressor_pkg::*;
#(
   parameter int unsigned SECTION_SIZE = DEF_SECTION_SIZE,
   parameter int unsigned ROW_SIZE     = DEF_ROW_SIZE,
   parameter int unsigned COMP_SIZE    = DEF_COMP_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ROW_SIZE-1:0]  rowData,
   output logic [COMP_SIZE-1:0] compressedData,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow
);

   localparam int unsigned NSECT   = COMP_SIZE / SECTION_SIZE;
   localparam int unsigned RUN_W   = $clog2(ROW_SIZE + 1);
   localparam int unsigned SECT_W  = $clog2(NSECT + 1);
   localparam int unsigned BIT_W   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam int unsigned RUN_MAX = (2 ** SECTION_SIZE) - 1;

   cmp_state_e            state_q, state_d;
   logic [ROW_SIZE-1:0]   row_q, row_d;
   logic [COMP_SIZE-1:0]  comp_q, comp_d;
   logic                  ovf_q, ovf_d;
   logic [RUN_W-1:0]      run_q, run_d;
   logic                  digit_q, digit_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [SECT_W-1:0]     sect_q, sect_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // A run can be stored only if it has a section left and fits its width.
   function automatic logic fits(input logic [SECT_W-1:0] idx, input logic [RUN_W-1:0] len);
      return (32'(idx) < NSECT) && (32'(len) <= RUN_MAX);
   endfunction

   // Return word with section idx replaced by len.
   function automatic logic [COMP_SIZE-1:0] put_sect(input logic [COMP_SIZE-1:0] word,
                                                     input logic [SECT_W-1:0]    idx,
                                                     input logic [RUN_W-1:0]     len);
      logic [COMP_SIZE-1:0] w;
      w = word;
      for (int unsigned k = 0; k < NSECT; k++) begin
         if (SECT_W'(k) == idx) begin
            w[k*SECTION_SIZE +: SECTION_SIZE] = SECTION_SIZE'(len);
         end
      end
      return w;
   endfunction

   // Next-state and datapath: one row bit consumed per SCAN cycle.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      comp_d  = comp_q;
      ovf_d   = ovf_q;
      run_d   = run_q;
      digit_d = digit_q;
      bit_d   = bit_q;
      sect_d  = sect_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               row_d   = rowData;
               comp_d  = '0;
               ovf_d   = 1'b0;
               run_d   = '0;
               digit_d = 1'b0;
               bit_d   = BIT_W'(ROW_SIZE - 1);
               sect_d  = '0;
               state_d = ST_SCAN;
            end
         end

         ST_SCAN: begin
            if (row_q[bit_q] == digit_q) begin
               run_d = RUN_W'(run_q + 1'b1);
            end else begin
               if (fits(sect_q, run_q)) begin
                  comp_d = put_sect(comp_q, sect_q, run_q);
               end else begin
                  ovf_d = 1'b1;
               end
               // Saturate at NSECT: any further write is already an overflow.
               if (32'(sect_q) < NSECT) begin
                  sect_d = SECT_W'(sect_q + 1'b1);
               end
               digit_d = ~digit_q;
               run_d   = RUN_W'(1);
            end

            if (bit_q == '0) begin
               // A trailing run of ones is flushed; trailing zeros are implied.
               if (digit_d) begin
                  if (fits(sect_d, run_d)) begin
                     comp_d = put_sect(comp_d, sect_d, run_d);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               state_d = ST_FINISH;
            end else begin
               bit_d = BIT_W'(bit_q - 1'b1);
            end
         end

         ST_FINISH: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         comp_q  <= '0;
         ovf_q   <= 1'b0;
         run_q   <= '0;
         digit_q <= 1'b0;
         bit_q   <= '0;
         sect_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         comp_q  <= comp_d;
         ovf_q   <= ovf_d;
         run_q   <= run_d;
         digit_q <= digit_d;
         bit_q   <= bit_d;
         sect_q  <= sect_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign compressedData = comp_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign overflow       = ovf_q;

endmodule

// File: tb/tb_row_compressor.sv
// Bench for row_compressor: directed rows, reset abort, random rows against a
// run-list model, and a compress/decompress loopback.
module tb_row_compressor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] row_data;
   logic [15:0] compressed_data;
   logic        busy;
   logic        done;
   logic        overflow;

   int n_chk = 0;
   int n_err = 0;

   row_compressor #(.SECTION_SIZE(4), .ROW_SIZE(16), .COMP_SIZE(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .rowData        (row_data),
      .compressedData (compressed_data),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: split the row into alternating runs (zeros first), drop a
   // trailing zero run, then place run k in section k if it fits.
   function automatic void model(input logic [15:0] row, output logic [15:0] cw, output logic ov);
      int   runs[$];
      int   len;
      logic dig;
      dig = 1'b0;
      len = 0;
      for (int i = 15; i >= 0; i--) begin
         if (row[i] == dig) len++;
         else begin
            runs.push_back(len);
            dig = ~dig;
            len = 1;
         end
      end
      if (dig) runs.push_back(len);
      cw = '0;
      ov = 1'b0;
      foreach (runs[k]) begin
         if (k < 4 && runs[k] <= 15) cw[k*4 +: 4] = 4'(runs[k]);
         else ov = 1'b1;
      end
   endfunction

   // Inverse mapping: emit the section lengths as alternating 0/1 runs.
   function automatic logic [15:0] decomp(input logic [15:0] cw);
      logic [15:0] r;
      int          pos;
      r   = '0;
      pos = 15;
      for (int k = 0; k < 4; k++) begin
         int n;
         n = int'(cw[k*4 +: 4]);
         for (int j = 0; j < n; j++) begin
            if (pos >= 0) begin
               r[pos] = (k % 2 == 1);
               pos--;
            end
         end
      end
      return r;
   endfunction

   // Issue one row and wait (bounded) for done; optionally poke start mid-scan.
   task automatic run_row(input logic [15:0] row, input bit poke,
                          output logic [15:0] cd, output logic ov);
      int lat;
      @(negedge clk);
      start    = 1'b1;
      row_data = row;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      check("busy_after_start", 32'(busy), 32'(1));
      while (done !== 1'b1 && lat < 40) begin
         if (poke && lat >= 3 && lat <= 5) begin
            start    = 1'b1;
            row_data = ~row;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      check("latency", 32'(lat), 32'(17));
      check("busy_at_done", 32'(busy), 32'(0));
      cd = compressed_data;
      ov = overflow;
   endtask

   logic [15:0] d_row [14] = '{16'hF00F, 16'h0F00, 16'h00FF, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h8000,
                               16'h0001, 16'h8001, 16'h7FFF, 16'h0F0F, 16'hF0F0, 16'hFF0F, 16'h5555};
   logic [15:0] d_cw  [14] = '{16'h4840, 16'h0044, 16'h0088, 16'h0000, 16'h0000, 16'h1110, 16'h0010,
                               16'h001F, 16'h1E10, 16'h00F1, 16'h4444, 16'h4440, 16'h4480, 16'h1111};
   logic        d_ov  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   logic [15:0] cd, exp_cw, row;
   logic        ov, exp_ov;
   int          done_seen;
   int          tries;

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      row_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cd", 32'(compressed_data), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_ovf", 32'(overflow), 32'(0));
      @(negedge clk);
      rst = 1'b1;

      // Directed rows, back to back, some with start pulsed while busy.
      for (int i = 0; i < 14; i++) begin
         run_row(d_row[i], (i % 3 == 1), cd, ov);
         check($sformatf("dir_cd_%h", d_row[i]), 32'(cd), 32'(d_cw[i]));
         check($sformatf("dir_ovf_%h", d_row[i]), 32'(ov), 32'(d_ov[i]));
      end

      // Result and overflow hold after done; done is a single pulse.
      run_row(16'hAAAA, 1'b0, cd, ov);
      @(posedge clk);
      #1;
      check("done_pulse", 32'(done), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      check("hold_cd", 32'(compressed_data), 32'(16'h1110));
      check("hold_ovf", 32'(overflow), 32'(1));

      // Reset in idle clears held overflow and result.
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_rst_ovf", 32'(overflow), 32'(0));
      check("idle_rst_cd", 32'(compressed_data), 32'(0));
      @(negedge clk);
      rst = 1'b1;

      // Reset after 8 scan cycles aborts the row; reset wins over start.
      @(negedge clk);
      start    = 1'b1;
      row_data = 16'hF00F;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("mid_scan_cd", 32'(compressed_data), 32'(16'h0040));
      check("mid_scan_busy", 32'(busy), 32'(1));
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      check("abort_cd", 32'(compressed_data), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_ovf", 32'(overflow), 32'(0));
      @(posedge clk);
      #1;
      check("rst_prio_busy", 32'(busy), 32'(0));
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'(0));
      run_row(16'h0F00, 1'b0, cd, ov);
      check("post_rst_cd", 32'(cd), 32'(16'h0044));
      check("post_rst_ovf", 32'(ov), 32'(0));

      // Uniform random rows against the model.
      for (int i = 0; i < 200; i++) begin
         row = 16'($urandom);
         model(row, exp_cw, exp_ov);
         run_row(row, (i % 7 == 0), cd, ov);
         check($sformatf("rnd_cd_%h", row), 32'(cd), 32'(exp_cw));
         check($sformatf("rnd_ovf_%h", row), 32'(ov), 32'(exp_ov));
      end

      // Loopback on representable rows.
      for (int i = 0; i < 1000; i++) begin
         tries = 0;
         do begin
            row = 16'($urandom);
            model(row, exp_cw, exp_ov);
            tries++;
         end while (exp_ov && tries < 500);
         if (exp_ov) begin
            row = 16'h0F00;
            model(row, exp_cw, exp_ov);
         end
         run_row(row, 1'b0, cd, ov);
         check($sformatf("loop_cd_%h", row), 32'(cd), 32'(exp_cw));
         check($sformatf("loop_ovf_%h", row), 32'(ov), 32'(0));
         check($sformatf("loop_row_%h", row), 32'(decomp(cd)), 32'(row));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
